// File: rtl/game_pkg.sv
// Shared pong-game types and screen-edge constants.
// The edge limits are also used by ball_ctl, so they live here rather than in game_ctl.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    localparam logic [10:0] LEFT_LIMIT   = 11'd8;
    localparam logic [10:0] RIGHT_LIMIT  = 11'd1015;
    localparam logic [3:0]  WIN_SCORE    = 4'd9;
    localparam int unsigned SERVE_CYCLES = 65_000_000;

    // Score increment that sticks at the winning value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
        return (score >= limit) ? limit : score + 4'd1;
    endfunction

endpackage

// File: rtl/game_ctl_if.sv
// Signal bundle between game_ctl, ball_ctl and the score-drawing stage.
// The slave side is game_ctl; the master side supplies ball position and start button.
interface game_ctl_if;

    logic [10:0] ball_xpos;
    logic        btn_start;
    logic        ball_move;
    logic        ball_serve;
    logic        serve_dir;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        game_over;

    modport master (
        output ball_xpos, btn_start,
        input  ball_move, ball_serve, serve_dir, score_l, score_r, game_over
    );

    modport slave (
        input  ball_xpos, btn_start,
        output ball_move, ball_serve, serve_dir, score_l, score_r, game_over
    );

endinterface

// File: rtl/game_ctl_serve_timer.sv
// Serve-delay counter: cleared by i_load, counts 0..CYCLES-1 while i_count is high.
// o_done flags the last count; the counter wraps back to 0 on that cycle.
module serve_timer #(
    parameter int unsigned CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_done
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] r_count;

    assign o_done = (r_count == W'(CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= o_done ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/game_ctl.sv
// Point/score state machine for pong: detects the ball leaving the field, keeps
// both scores, and freezes/serves the ball through ball_ctl.
module game_ctl
    import game_pkg::*;
#(
    parameter logic [10:0] P_LEFT_LIMIT   = LEFT_LIMIT,
    parameter logic [10:0] P_RIGHT_LIMIT  = RIGHT_LIMIT,
    parameter logic [3:0]  WIN_SCORE      = game_pkg::WIN_SCORE,
    parameter int unsigned SERVE_CYCLES   = game_pkg::SERVE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    game_ctl_if.slave  bus
);

    state_t     r_state;
    logic       r_btn_q;
    logic       r_ball_move;
    logic       r_ball_serve;
    logic       r_serve_dir;
    logic [3:0] r_score_l;
    logic [3:0] r_score_r;
    logic       r_game_over;

    logic w_start_re;
    logic w_in_wait;
    logic w_timer_done;

    assign w_start_re = bus.btn_start & ~r_btn_q;
    assign w_in_wait  = (r_state == SERVE_WAIT);

    serve_timer #(.CYCLES(SERVE_CYCLES)) u_serve_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (~w_in_wait),
        .i_count (w_in_wait),
        .o_done  (w_timer_done)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values of the other registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_btn_q      <= 1'b0;
            r_ball_move  <= 1'b0;
            r_ball_serve <= 1'b0;
            r_serve_dir  <= 1'b0;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_game_over  <= 1'b0;
        end else begin
            r_btn_q      <= bus.btn_start;
            r_ball_serve <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_ball_move <= 1'b0;
                    if (w_start_re) begin
                        r_score_l    <= 4'd0;
                        r_score_r    <= 4'd0;
                        r_serve_dir  <= 1'b0;
                        r_ball_serve <= 1'b1;
                        r_state      <= SERVE_WAIT;
                    end
                end

                SERVE_WAIT: begin
                    r_ball_move <= 1'b0;
                    if (w_timer_done) begin
                        r_ball_move <= 1'b1;
                        r_state     <= PLAY;
                    end
                end

                PLAY: begin
                    // Left exit wins ties with the right limit check.
                    if (bus.ball_xpos <= P_LEFT_LIMIT) begin
                        r_score_r   <= sat_inc(r_score_r, WIN_SCORE);
                        r_serve_dir <= 1'b0;
                        r_ball_move <= 1'b0;
                        r_state     <= POINT;
                    end else if (bus.ball_xpos >= P_RIGHT_LIMIT) begin
                        r_score_l   <= sat_inc(r_score_l, WIN_SCORE);
                        r_serve_dir <= 1'b1;
                        r_ball_move <= 1'b0;
                        r_state     <= POINT;
                    end
                end

                POINT: begin
                    r_ball_move <= 1'b0;
                    if (r_score_l == WIN_SCORE || r_score_r == WIN_SCORE) begin
                        r_game_over <= 1'b1;
                        r_state     <= GAME_OVER;
                    end else begin
                        r_ball_serve <= 1'b1;
                        r_state      <= SERVE_WAIT;
                    end
                end

                GAME_OVER: begin
                    r_ball_move <= 1'b0;
                    if (w_start_re) begin
                        r_score_l    <= 4'd0;
                        r_score_r    <= 4'd0;
                        r_game_over  <= 1'b0;
                        r_serve_dir  <= 1'b0;
                        r_ball_serve <= 1'b1;
                        r_state      <= SERVE_WAIT;
                    end
                end

                default: begin
                    r_ball_move <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ball_move  = r_ball_move;
    assign bus.ball_serve = r_ball_serve;
    assign bus.serve_dir  = r_serve_dir;
    assign bus.score_l    = r_score_l;
    assign bus.score_r    = r_score_r;
    assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_game_ctl.sv
// Directed scoreboard bench for game_ctl with SERVE_CYCLES=10 and WIN_SCORE=3.
// Expected outputs are queued as each step is driven and popped after the clock edge.
module tb_game_ctl;
    import game_pkg::*;

    typedef struct {
        string      tag;
        logic       move;
        logic       serve;
        logic       dir;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    game_ctl_if bus ();

    game_ctl #(
        .SERVE_CYCLES (10),
        .WIN_SCORE    (4'd3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic cmp(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=0 expected>0");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "ball_move",  {3'b0, bus.ball_move},  {3'b0, e.move});
        cmp(e.tag, "ball_serve", {3'b0, bus.ball_serve}, {3'b0, e.serve});
        cmp(e.tag, "serve_dir",  {3'b0, bus.serve_dir},  {3'b0, e.dir});
        cmp(e.tag, "score_l",    bus.score_l,            e.sl);
        cmp(e.tag, "score_r",    bus.score_r,            e.sr);
        cmp(e.tag, "game_over",  {3'b0, bus.game_over},  {3'b0, e.go});
    endtask

    task automatic expect_out(input string tag, input logic move, input logic serve, input logic dir,
                              input logic [3:0] sl, input logic [3:0] sr, input logic go);
        exp_t e;
        e.tag = tag; e.move = move; e.serve = serve; e.dir = dir;
        e.sl = sl; e.sr = sr; e.go = go;
        sb.push_back(e);
    endtask

    task automatic step(input string tag, input logic move, input logic serve, input logic dir,
                        input logic [3:0] sl, input logic [3:0] sr, input logic go);
        expect_out(tag, move, serve, dir, sl, sr, go);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic wait_play(input int n_zero, input logic dir, input logic [3:0] sl, input logic [3:0] sr);
        for (int i = 0; i < n_zero; i++) step("serve_wait", 1'b0, 1'b0, dir, sl, sr, 1'b0);
        step("enter_play", 1'b1, 1'b0, dir, sl, sr, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        n_assert++;
        assert (dut.r_state === IDLE) else begin
            n_fail++;
            $error("FAIL %s.state observed=%0d expected=%0d", tag, dut.r_state, IDLE);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.ball_xpos = 11'd500;
        bus.btn_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check();
        check_idle("reset");

        // Start: one serve pulse, ten frozen cycles, then play.
        bus.btn_start = 1'b1;
        step("start_serve", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        bus.btn_start = 1'b0;
        wait_play(9, 1'b0, 4'd0, 4'd0);

        // Just inside both limits: no point.
        bus.ball_xpos = 11'd9;
        step("inside_left", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        bus.ball_xpos = 11'd1014;
        step("inside_right", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        // Left exit: right player scores.
        bus.ball_xpos = 11'd5;
        step("hit_left", 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0);
        bus.ball_xpos = 11'd500;
        step("point_serve_l", 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
        wait_play(9, 1'b0, 4'd0, 4'd1);

        // Right exits until the left player wins.
        for (int k = 1; k <= 3; k++) begin
            bus.ball_xpos = (k == 1) ? 11'd1020 : 11'd1015;
            step("hit_right", 1'b0, 1'b0, 1'b1, 4'(k), 4'd1, 1'b0);
            bus.ball_xpos = 11'd500;
            if (k < 3) begin
                step("point_serve_r", 1'b0, 1'b1, 1'b1, 4'(k), 4'd1, 1'b0);
                wait_play(9, 1'b1, 4'(k), 4'd1);
            end else begin
                step("game_over", 1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b1);
            end
        end
        bus.ball_xpos = 11'd0;
        for (int i = 0; i < 3; i++) step("game_over_hold", 1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b1);
        bus.ball_xpos = 11'd500;

        // Held start button restarts exactly once.
        bus.btn_start = 1'b1;
        step("restart", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) step("restart_held", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        bus.btn_start = 1'b0;
        wait_play(5, 1'b0, 4'd0, 4'd0);

        // Button activity during play is ignored.
        for (int i = 0; i < 6; i++) begin
            bus.btn_start = (i % 2 == 0);
            step("play_btn", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        end
        bus.btn_start = 1'b0;

        // Exactly on the left limit, then ball parked off-field while serving.
        bus.ball_xpos = 11'd8;
        step("hit_left_edge", 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0);
        bus.ball_xpos = 11'd0;
        step("point_serve_edge", 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);
        wait_play(9, 1'b0, 4'd0, 4'd1);
        bus.ball_xpos = 11'd500;

        // Reset during play.
        rst = 1'b1;
        step("rst_play", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check_idle("rst_play");
        rst = 1'b0;

        // Reset mid-serve with the timer at 4, then a clean full serve.
        bus.btn_start = 1'b1;
        step("serve_again", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        bus.btn_start = 1'b0;
        for (int i = 0; i < 4; i++) step("serve_partial", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b1;
        step("rst_serve", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check_idle("rst_serve");
        rst = 1'b0;
        bus.btn_start = 1'b1;
        step("serve_after_rst", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        bus.btn_start = 1'b0;
        wait_play(9, 1'b0, 4'd0, 4'd0);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
